// File: rtl/rgb_mul_scheduler.sv
// Round-robin scheduler sharing one registered RGB channel multiplier among N_REQ requesters.
// Optional activity counters (stat_grants, stat_stalls) are built when RGB_SCHED_STATS_EN is defined.
//
// state  | meaning
// IDLE   | grant lowest valid index at or after rr_ptr, capture operands
// ISS_R  | multiplier start with R operands
// ISS_G  | start with G operands, capture R result
// ISS_B  | start with B operands, capture G result
// WAIT   | multiplier idle, capture B result
// RESP   | hold response until rsp_ready
module rgb_mul_scheduler #(
  parameter int N_REQ     = 4,
  parameter int WIDTH     = 24,
  parameter int Q_BITS    = 12,
  parameter int RGB_WIDTH = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [N_REQ-1:0]                 req_valid,
  output logic [N_REQ-1:0]                 req_ready,
  input  logic [N_REQ*3*RGB_WIDTH-1:0]     req_color,
  input  logic [N_REQ*3*RGB_WIDTH-1:0]     req_scale,
  output logic                             rsp_valid,
  input  logic                             rsp_ready,
  output logic [$clog2(N_REQ)-1:0]         rsp_id,
  output logic signed [WIDTH-1:0]          rsp_r,
  output logic signed [WIDTH-1:0]          rsp_g,
  output logic signed [WIDTH-1:0]          rsp_b
`ifdef RGB_SCHED_STATS_EN
  ,
  output logic [15:0]                      stat_grants,
  output logic [15:0]                      stat_stalls
`endif
);

  localparam int ID_W  = $clog2(N_REQ);
  localparam int PIX_W = 3 * RGB_WIDTH;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ISS_R = 3'd1;
  localparam logic [2:0] S_ISS_G = 3'd2;
  localparam logic [2:0] S_ISS_B = 3'd3;
  localparam logic [2:0] S_WAIT  = 3'd4;
  localparam logic [2:0] S_RESP  = 3'd5;

  logic [2:0]             state;
  logic [ID_W-1:0]        rr_ptr;
  logic [ID_W-1:0]        grant_id;
  logic [ID_W-1:0]        cand;
  logic [N_REQ-1:0]       grant;
  logic                   found;
  logic                   accept;
  logic [PIX_W-1:0]       sel_col;
  logic [PIX_W-1:0]       sel_scl;
  logic [PIX_W-1:0]       col_q;
  logic [PIX_W-1:0]       scl_q;
  logic                   mul_start;
  logic [RGB_WIDTH-1:0]   mul_a;
  logic [RGB_WIDTH-1:0]   mul_b;
  logic [2*RGB_WIDTH-1:0] mul_p;
  logic [WIDTH-1:0]       mul_res;
  logic                   unused_lsb;

  // Search starts at rr_ptr and wraps, so every held request is served within N_REQ grants.
  always_comb begin
    grant    = '0;
    grant_id = '0;
    found    = 1'b0;
    cand     = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = ID_W'((int'(rr_ptr) + k) % N_REQ);
      if (!found && req_valid[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        grant_id    = cand;
      end
    end
  end

  always_comb begin
    sel_col = '0;
    sel_scl = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) begin
        sel_col = req_color[i*PIX_W +: PIX_W];
        sel_scl = req_scale[i*PIX_W +: PIX_W];
      end
    end
  end

  assign accept    = (state == S_IDLE) && found;
  assign req_ready = (state == S_IDLE) ? grant : '0;
  assign rsp_valid = (state == S_RESP);

  always_comb begin
    mul_start = 1'b0;
    mul_a     = '0;
    mul_b     = '0;
    case (state)
      S_ISS_R: begin
        mul_start = 1'b1;
        mul_a     = col_q[3*RGB_WIDTH-1 -: RGB_WIDTH];
        mul_b     = scl_q[3*RGB_WIDTH-1 -: RGB_WIDTH];
      end
      S_ISS_G: begin
        mul_start = 1'b1;
        mul_a     = col_q[2*RGB_WIDTH-1 -: RGB_WIDTH];
        mul_b     = scl_q[2*RGB_WIDTH-1 -: RGB_WIDTH];
      end
      S_ISS_B: begin
        mul_start = 1'b1;
        mul_a     = col_q[RGB_WIDTH-1:0];
        mul_b     = scl_q[RGB_WIDTH-1:0];
      end
      default: ;
    endcase
  end

  // Shared multiplier: one-cycle latency, output forced to zero when not started.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mul_p <= '0;
    end else if (mul_start) begin
      mul_p <= {{RGB_WIDTH{1'b0}}, mul_a} * {{RGB_WIDTH{1'b0}}, mul_b};
    end else begin
      mul_p <= '0;
    end
  end

  // Only the product's upper half lands in the Q-format result; low bits are truncated.
  always_comb begin
    mul_res = '0;
    mul_res[Q_BITS+RGB_WIDTH-1:Q_BITS] = mul_p[2*RGB_WIDTH-1:RGB_WIDTH];
  end

  assign unused_lsb = ^mul_p[RGB_WIDTH-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      rr_ptr <= '0;
      col_q  <= '0;
      scl_q  <= '0;
      rsp_id <= '0;
      rsp_r  <= '0;
      rsp_g  <= '0;
      rsp_b  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            col_q  <= sel_col;
            scl_q  <= sel_scl;
            rsp_id <= grant_id;
            rr_ptr <= (grant_id == ID_W'(N_REQ - 1)) ? '0 : grant_id + ID_W'(1);
            state  <= S_ISS_R;
          end
        end
        S_ISS_R: state <= S_ISS_G;
        S_ISS_G: begin
          rsp_r <= $signed(mul_res);
          state <= S_ISS_B;
        end
        S_ISS_B: begin
          rsp_g <= $signed(mul_res);
          state <= S_WAIT;
        end
        S_WAIT: begin
          rsp_b <= $signed(mul_res);
          state <= S_RESP;
        end
        S_RESP: begin
          if (rsp_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef RGB_SCHED_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_grants <= '0;
      stat_stalls <= '0;
    end else begin
      if (accept && (stat_grants != 16'hFFFF)) stat_grants <= stat_grants + 16'd1;
      if ((state == S_RESP) && !rsp_ready && (stat_stalls != 16'hFFFF))
        stat_stalls <= stat_stalls + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_rgb_mul_scheduler.sv
// Scoreboard bench for rgb_mul_scheduler: directed requests push expected responses,
// a negedge monitor pops and compares on each response handshake.
module tb_rgb_mul_scheduler;

  logic          clk = 1'b0;
  logic          rst;
  logic [3:0]    req_valid;
  logic [3:0]    req_ready;
  logic [95:0]   req_color;
  logic [95:0]   req_scale;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [1:0]    rsp_id;
  logic signed [23:0] rsp_r, rsp_g, rsp_b;
`ifdef RGB_SCHED_STATS_EN
  logic [15:0]   stat_grants, stat_stalls;
`endif

  rgb_mul_scheduler #(.N_REQ(4), .WIDTH(24), .Q_BITS(12), .RGB_WIDTH(8)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_color(req_color), .req_scale(req_scale),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_r(rsp_r), .rsp_g(rsp_g), .rsp_b(rsp_b)
`ifdef RGB_SCHED_STATS_EN
    , .stat_grants(stat_grants), .stat_stalls(stat_stalls)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  id;
    logic [23:0] r;
    logic [23:0] g;
    logic [23:0] b;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   last_acc = 0;
  bit   in_resp = 1'b0;
  logic [73:0] snap;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [23:0] chan(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = a * b;
    return {4'h0, p[15:8], 12'h000};
  endfunction

  function automatic exp_t mk(input int id, input logic [23:0] col, input logic [23:0] scl);
    exp_t e;
    e.id = id[1:0];
    e.r  = chan(col[23:16], scl[23:16]);
    e.g  = chan(col[15:8],  scl[15:8]);
    e.b  = chan(col[7:0],   scl[7:0]);
    return e;
  endfunction

  // Monitor: latency, stability under back-pressure, grant blocking, scoreboard pop.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      in_resp = 1'b0;
    end else begin
      if (rsp_valid) begin
        if (!in_resp) begin
          in_resp = 1'b1;
          chk("rsp_latency", cyc - last_acc, 5);
          snap = {rsp_id, rsp_r, rsp_g, rsp_b};
        end else begin
          chk("rsp_stable", {rsp_id, rsp_r, rsp_g, rsp_b}, snap);
        end
        chk("ready_in_resp", req_ready, 4'b0000);
        if (rsp_ready) begin
          if (sb.size() == 0) begin
            chk("unexpected_rsp", sb.size(), 1);
          end else begin
            e = sb.pop_front();
            chk("rsp_id", rsp_id, e.id);
            chk("rsp_r", $unsigned(rsp_r), e.r);
            chk("rsp_g", $unsigned(rsp_g), e.g);
            chk("rsp_b", $unsigned(rsp_b), e.b);
          end
          in_resp = 1'b0;
        end
      end
      if (|(req_valid & req_ready)) last_acc = cyc;
    end
  end

  task automatic set_req(input int i, input logic [23:0] col, input logic [23:0] scl);
    req_color[i*24 +: 24] = col;
    req_scale[i*24 +: 24] = scl;
    req_valid[i] = 1'b1;
  endtask

  task automatic wait_grant(input int exp_i, output int gc);
    int n;
    logic [3:0] e;
    n = 0;
    gc = -1;
    e = '0;
    e[exp_i] = 1'b1;
    while (n < 60) begin
      @(negedge clk);
      n++;
      if (|(req_valid & req_ready)) begin
        gc = cyc;
        chk("grant", req_ready, e);
        break;
      end
    end
    if (gc < 0) chk("grant_timeout", n, 0);
  endtask

  task automatic wait_rsp();
    int n;
    n = 0;
    while (n < 60) begin
      @(negedge clk);
      n++;
      if (rsp_valid) break;
    end
    if (!rsp_valid) chk("rsp_timeout", n, 0);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || rsp_valid) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drain", sb.size(), 0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    int c[5];
    int g;
    logic [23:0] fc[4];
    logic [23:0] fs[4];
    fc = '{24'hFF8010, 24'h40C0FF, 24'h123456, 24'hFEFEFE};
    fs = '{24'h10FF80, 24'hFF02FF, 24'h808080, 24'hFFFF01};

    rst = 1'b1;
    rsp_ready = 1'b1;
    req_valid = '0;
    req_color = '0;
    req_scale = '0;
    repeat (2) @(negedge clk);
    chk("reset_req_ready", req_ready, 4'b0000);
    chk("reset_rsp_valid", rsp_valid, 1'b0);
    chk("reset_rsp_id", rsp_id, 2'd0);
    chk("reset_rsp_r", $unsigned(rsp_r), 24'd0);
    chk("reset_rsp_g", $unsigned(rsp_g), 24'd0);
    chk("reset_rsp_b", $unsigned(rsp_b), 24'd0);
`ifdef RGB_SCHED_STATS_EN
    chk("reset_stat_grants", stat_grants, 16'd0);
    chk("reset_stat_stalls", stat_stalls, 16'd0);
`endif
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("idle_no_req_ready", req_ready, 4'b0000);

    // Single request from requester 2
    @(posedge clk); #1;
    sb.push_back(exp_t'{2'd2, 24'h0FE000, 24'h040000, 24'h000000});
    set_req(2, {8'd255, 8'd128, 8'd0}, {8'd255, 8'd128, 8'd77});
    wait_grant(2, g);
    @(posedge clk); #1;
    req_valid[2] = 1'b0;
    drain();

    // Round-robin fairness with all requesters held valid
    do_reset();
    for (int i = 0; i < 4; i++) set_req(i, fc[i], fs[i]);
    for (int i = 0; i < 4; i++) sb.push_back(mk(i, fc[i], fs[i]));
    sb.push_back(mk(0, fc[0], fs[0]));
    wait_grant(0, c[0]);
    wait_grant(1, c[1]);
    wait_grant(2, c[2]);
    wait_grant(3, c[3]);
    wait_grant(0, c[4]);
    @(posedge clk); #1;
    req_valid = '0;
    for (int i = 1; i < 5; i++) chk("accept_spacing", c[i] - c[i-1], 6);
    drain();

    // Back-pressure: 10 stall cycles in RESP while requester 0 waits
    do_reset();
    rsp_ready = 1'b0;
    sb.push_back(exp_t'{2'd1, 24'h007000, 24'h007000, 24'h005000});
    set_req(1, {8'd200, 8'd100, 8'd50}, {8'd10, 8'd20, 8'd30});
    wait_grant(1, g);
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    set_req(0, 24'h010203, 24'h040506);
    sb.push_back(exp_t'{2'd0, 24'h0, 24'h0, 24'h0});
    wait_rsp();
    repeat (10) @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    @(negedge clk);
`ifdef RGB_SCHED_STATS_EN
    chk("stat_grants", stat_grants, 16'd1);
    chk("stat_stalls", stat_stalls, 16'd10);
`endif
    wait_grant(0, g);
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    drain();

    // Reset during ISS_G after a grant to 1 (pointer would otherwise sit at 2)
    do_reset();
    set_req(1, 24'h112233, 24'h445566);
    wait_grant(1, g);
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_rsp_valid", rsp_valid, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (8) begin
      @(negedge clk);
      chk("midrst_no_rsp", rsp_valid, 1'b0);
    end

    // Only 1 and 3 valid: pointer restarts at 0, then alternates and wraps 3 -> 1
    @(posedge clk); #1;
    set_req(1, 24'hA0B0C0, 24'h0F1F2F);
    set_req(3, 24'h998877, 24'hFFFFFF);
    sb.push_back(mk(1, 24'hA0B0C0, 24'h0F1F2F));
    sb.push_back(mk(3, 24'h998877, 24'hFFFFFF));
    sb.push_back(mk(1, 24'hA0B0C0, 24'h0F1F2F));
    sb.push_back(mk(3, 24'h998877, 24'hFFFFFF));
    wait_grant(1, g);
    wait_grant(3, g);
    wait_grant(1, g);
    wait_grant(3, g);
    @(posedge clk); #1;
    req_valid = '0;
    drain();

    // Arithmetic extremes: 255*1 truncates to 0, 0*0 is 0, 255*255 keeps 0xFE
    @(posedge clk); #1;
    sb.push_back(exp_t'{2'd0, 24'h000000, 24'h000000, 24'h0FE000});
    set_req(0, {8'd255, 8'd0, 8'd255}, {8'd1, 8'd0, 8'd255});
    wait_grant(0, g);
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    drain();

    chk("scoreboard_left", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got %0d cycles expected completion", cyc);
    $fatal(1, "timeout");
  end

endmodule
